// File: rtl/freq_meter_pkg.sv
// Shared types, default sizes and a constant-width helper for the freq_meter block.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } meter_state_e;

  localparam int DEF_CNT_W    = 20;
  localparam int DEF_GATE_CYC = 12000000;

  // Number of bits needed to hold the values 0..v-1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_chan.sv
// One measured channel: input synchroniser, rising-edge detect and a saturating
// window counter with its overflow flag, all in the clk_sys domain.
module freq_meter_chan
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  input  logic             lat,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             ovf_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_s;

  // cnt_nxt/ovf_nxt include this cycle's edge so a latch never loses it.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    edge_s  = sync_q[SYNC_STAGES-1] & ~prev_q;
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (edge_s && (cnt_q == CNT_MAX)) begin
      ovf_nxt = 1'b1;
    end else if (edge_s) begin
      cnt_nxt = cnt_q + CNT_ONE;
    end else begin
      cnt_nxt = cnt_q;
    end
    if (clr || lat) begin
      cnt_d = CNT_ZERO;
      ovf_d = 1'b0;
    end else begin
      cnt_d = cnt_nxt;
      ovf_d = ovf_nxt;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
      cnt_q  <= CNT_ZERO;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Multi-channel gate-window frequency meter. Defining FREQ_METER_ERR_EN adds the
// err_flat port carrying signed (count - NOMINAL_CNT) per channel.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_CYC    = DEF_GATE_CYC,
  parameter int SYNC_STAGES = 2,
  parameter int NOMINAL_CNT = 0
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [NCH-1:0]       sig_in,
  input  logic                 run,
  output logic [NCH*CNT_W-1:0] freq_flat,
  output logic [NCH-1:0]       ovf,
  output logic                 valid,
  output logic                 busy
`ifdef FREQ_METER_ERR_EN
  ,
  output logic [NCH*(CNT_W+1)-1:0] err_flat
`endif
);

  localparam int             GW        = clog2_f(GATE_CYC);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYC - 1);
  localparam logic [GW-1:0]  GATE_ONE  = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]  GATE_ZERO = {GW{1'b0}};

  meter_state_e         state_q, state_d;
  logic [GW-1:0]        gate_q, gate_d;
  logic [NCH*CNT_W-1:0] freq_q, freq_d;
  logic [NCH-1:0]       ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 clr_s, lat_s;
  logic [NCH*CNT_W-1:0] cnt_nxt_flat;
  logic [NCH-1:0]       ovf_nxt_vec;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    freq_meter_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_sys(clk_sys),
      .rst    (rst),
      .sig_in (sig_in[i]),
      .clr    (clr_s),
      .lat    (lat_s),
      .cnt_nxt(cnt_nxt_flat[i*CNT_W +: CNT_W]),
      .ovf_nxt(ovf_nxt_vec[i])
    );
  end

  // Gate FSM; terminal count wins over a same-cycle run drop so the window still publishes.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    clr_s   = 1'b0;
    lat_s   = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d = GATE_ZERO;
        clr_s  = 1'b1;
        if (run) begin
          state_d = MEAS;
        end else begin
          state_d = IDLE;
        end
      end
      MEAS: begin
        if (gate_q == GATE_LAST) begin
          lat_s   = 1'b1;
          valid_d = 1'b1;
          gate_d  = GATE_ZERO;
          freq_d  = cnt_nxt_flat;
          ovf_d   = ovf_nxt_vec;
          state_d = run ? MEAS : IDLE;
        end else if (!run) begin
          clr_s   = 1'b1;
          gate_d  = GATE_ZERO;
          state_d = IDLE;
        end else begin
          gate_d  = gate_q + GATE_ONE;
        end
      end
      default: begin
        clr_s   = 1'b1;
        gate_d  = GATE_ZERO;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == MEAS);
  end

  // FSM, gate counter and published result registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= GATE_ZERO;
      freq_q  <= {(NCH*CNT_W){1'b0}};
      ovf_q   <= {NCH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign freq_flat = freq_q;
  assign ovf       = ovf_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

`ifdef FREQ_METER_ERR_EN
  localparam logic [CNT_W:0] NOM_VAL = (CNT_W+1)'(NOMINAL_CNT);

  logic [NCH*(CNT_W+1)-1:0] err_q, err_d;

  // A saturated count is already all-ones, so the overflow case falls out of the subtraction.
  always_comb begin
    err_d = err_q;
    if (lat_s) begin
      for (int i = 0; i < NCH; i++) begin
        err_d[i*(CNT_W+1) +: (CNT_W+1)] = {1'b0, cnt_nxt_flat[i*CNT_W +: CNT_W]} - NOM_VAL;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Error result register, updated together with freq_flat.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      err_q <= {(NCH*(CNT_W+1)){1'b0}};
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flat = err_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYC=100, SYNC_STAGES=2, CNT_W=5).
// With FREQ_METER_ERR_EN defined the err_flat outputs are checked as well.
module tb_freq_meter;

  localparam int NCH = 4;
  localparam int CW  = 5;
  localparam int G   = 100;
  localparam int S   = 2;
  localparam int NOM = 10;
  localparam int MAX = 31;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic [NCH-1:0]      sig_in = '0;
  logic [NCH*CW-1:0]   freq_flat;
  logic [NCH-1:0]      ovf;
  logic                valid;
  logic                busy;
`ifdef FREQ_METER_ERR_EN
  logic [NCH*(CW+1)-1:0] err_flat;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int per[NCH] = '{0, 0, 0, 0};

  // Reference model state
  bit m_smp[NCH][S+1];
  int m_cnt[NCH];
  int m_lat[NCH];
  bit m_ovf[NCH];
  bit m_open  = 1'b0;
  bit m_valid = 1'b0;
  int m_gate  = 0;

  freq_meter #(
    .NCH(NCH), .CNT_W(CW), .GATE_CYC(G), .SYNC_STAGES(S), .NOMINAL_CNT(NOM)
  ) u_dut (
    .clk_sys  (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .run      (run),
    .freq_flat(freq_flat),
    .ovf      (ovf),
    .valid    (valid),
    .busy     (busy)
`ifdef FREQ_METER_ERR_EN
    ,
    .err_flat (err_flat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int fq(input int ch);
    return int'(freq_flat[ch*CW +: CW]);
  endfunction

`ifdef FREQ_METER_ERR_EN
  function automatic int er(input int ch);
    logic signed [CW:0] v;
    v = err_flat[ch*(CW+1) +: (CW+1)];
    return int'(v);
  endfunction
`endif

  function automatic logic gen(input int p, input int t);
    if (p == 0) return 1'b0;
    return (t % p) < (p / 2);
  endfunction

  // Square-wave generator: period per[ch] cycles, 0 = held low.
  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      t++;
      for (int ch = 0; ch < NCH; ch++) sig_in[ch] = gen(per[ch], t);
    end
  end

  // Model: an edge counts S cycles after it is first sampled; windows are G cycles long.
  initial begin
    bit ev[NCH];
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_open = 1'b0; m_valid = 1'b0; m_gate = 0;
        for (int ch = 0; ch < NCH; ch++) begin
          m_cnt[ch] = 0; m_lat[ch] = 0; m_ovf[ch] = 1'b0;
          for (int k = 0; k <= S; k++) m_smp[ch][k] = 1'b0;
        end
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          ev[ch] = m_smp[ch][S-1] && !m_smp[ch][S];
          for (int k = S; k > 0; k--) m_smp[ch][k] = m_smp[ch][k-1];
          m_smp[ch][0] = sig_in[ch];
        end
        m_valid = 1'b0;
        if (m_open) begin
          for (int ch = 0; ch < NCH; ch++) m_cnt[ch] += int'(ev[ch]);
          if (m_gate == G - 1) begin
            for (int ch = 0; ch < NCH; ch++) begin
              m_lat[ch] = (m_cnt[ch] > MAX) ? MAX : m_cnt[ch];
              m_ovf[ch] = (m_cnt[ch] > MAX);
              m_cnt[ch] = 0;
            end
            m_valid = 1'b1;
            m_gate  = 0;
            m_open  = run;
          end else if (!run) begin
            m_open = 1'b0;
            m_gate = 0;
            for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
          end else begin
            m_gate++;
          end
        end else if (run) begin
          m_open = 1'b1;
          m_gate = 0;
          for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", int'(valid), int'(m_valid));
        chk("busy", int'(busy), int'(m_open));
        for (int ch = 0; ch < NCH; ch++) begin
          chk($sformatf("freq[%0d]", ch), fq(ch), m_lat[ch]);
          chk($sformatf("ovf[%0d]", ch), int'(ovf[ch]), int'(m_ovf[ch]));
`ifdef FREQ_METER_ERR_EN
          chk($sformatf("err[%0d]", ch), er(ch), m_lat[ch] - NOM);
`endif
        end
      end
    end
  end

  // Wait for the next valid strobe, counting rising edges; bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 400);
    chk("valid_seen", int'(valid), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_freq", int'(freq_flat), 0);
    chk("rst_ovf", int'(ovf), 0);

    per = '{10, 4, 0, 0};
    repeat (5) @(posedge clk);
    #1 run = 1'b1;
    wait_valid(n);
    chk("first_valid_lat", n, 101);
    wait_valid(n);
    chk("valid_spacing", n, 100);
    chk("lit_ch0_p10", fq(0), 10);
    chk("lit_ch1_p4", fq(1), 25);
    chk("lit_ch2_low", fq(2), 0);
    chk("lit_ovf_clear", int'(ovf), 0);
`ifdef FREQ_METER_ERR_EN
    chk("lit_err0", er(0), 0);
    chk("lit_err1", er(1), 15);
    chk("lit_err2", er(2), -10);
`endif

    per[0] = 2;
    wait_valid(n);
    wait_valid(n);
    chk("lit_sat_cnt", fq(0), 31);
    chk("lit_sat_ovf", int'(ovf[0]), 1);
    chk("lit_sat_ch1", fq(1), 25);
`ifdef FREQ_METER_ERR_EN
    chk("lit_sat_err", er(0), 21);
`endif
    per[0] = 10;
    wait_valid(n);
    wait_valid(n);
    chk("lit_recover_cnt", fq(0), 10);
    chk("lit_recover_ovf", int'(ovf[0]), 0);

    repeat (50) @(posedge clk);
    #1 run = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("lit_abort_hold", fq(0), 10);
    chk("lit_abort_busy", int'(busy), 0);
    run = 1'b1;
    wait_valid(n);
    chk("lit_rerun_lat", n, 101);
    chk("lit_rerun_cnt", fq(0), 10);

    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("lit_arst_freq", int'(freq_flat), 0);
    chk("lit_arst_ovf", int'(ovf), 0);
    chk("lit_arst_valid", int'(valid), 0);
    chk("lit_arst_busy", int'(busy), 0);
`ifdef FREQ_METER_ERR_EN
    chk("lit_arst_err", int'(err_flat), 0);
`endif
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
